// File: rtl/keypad_entry_pkg.sv
// Shared definitions for the keypad digit-entry controller.
// Holds the default command key codes, the overflow-mode selectors, the
// controller state encoding and a key classification helper.
package keypad_entry_pkg;

  // Default command key codes
  localparam logic [3:0] KeyEnter = 4'hA;
  localparam logic [3:0] KeyBack  = 4'hB;
  localparam logic [3:0] KeyClr   = 4'hC;

  // Overflow policy selectors
  localparam int unsigned OvfSat   = 0;  // extra digits are dropped
  localparam int unsigned OvfShift = 1;  // oldest digit is discarded

  typedef enum logic [0:0] {
    StEntry,
    StHold
  } state_e;

  typedef enum logic [1:0] {
    KindDigit,
    KindEnter,
    KindBack,
    KindClr
  } key_kind_e;

  // Command matches take priority over digits; enter wins if codes collide.
  function automatic key_kind_e classify_key(input logic [3:0] code,
                                             input logic [3:0] enter_code,
                                             input logic [3:0] back_code,
                                             input logic [3:0] clr_code);
    if (code == enter_code) begin
      return KindEnter;
    end else if (code == back_code) begin
      return KindBack;
    end else if (code == clr_code) begin
      return KindClr;
    end
    return KindDigit;
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Bundle of keypad-side inputs, live display outputs and the committed-entry
// valid/ready handshake of keypad_entry.
//   master : drives key_valid, key_code, out_ready (keypad + consumer side)
//   slave  : drives disp, count, out_data, out_valid, overflow, timeout, busy
interface keypad_entry_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned CntW = $clog2(DIGITS + 1);

  logic                  key_valid;
  logic [3:0]            key_code;
  logic [DIGITS*4-1:0]   disp;
  logic [CntW-1:0]       count;
  logic [DIGITS*4-1:0]   out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  overflow;
  logic                  timeout;
  logic                  busy;

  modport master (
    output key_valid, key_code, out_ready,
    input  disp, count, out_data, out_valid, overflow, timeout, busy
  );

  modport slave (
    input  key_valid, key_code, out_ready,
    output disp, count, out_data, out_valid, overflow, timeout, busy
  );

endinterface

// File: rtl/keypad_entry_digit_buffer.sv
// Nibble shift register holding up to DIGITS hex digits, newest digit in the
// least-significant nibble.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : shift digit_i in (saturate or shift when full)
//   pop_i         : drop the newest digit (no-op when empty)
//   clr_i         : empty the buffer (takes priority over push/pop)
//   digit_i       : nibble to push
//   disp_o        : buffer contents
//   count_o       : digits held
//   ovf_o         : one-cycle pulse when a push arrives while full
module keypad_entry_digit_buffer
  import keypad_entry_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned OVF_SHIFT = OvfSat,
  localparam int unsigned W        = DIGITS * 4,
  localparam int unsigned CntW     = $clog2(DIGITS + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            clr_i,
  input  logic [3:0]      digit_i,
  output logic [W-1:0]    disp_o,
  output logic [CntW-1:0] count_o,
  output logic            ovf_o
);

  localparam logic [CntW-1:0] Full = CntW'(DIGITS);

  logic [W-1:0]    disp_q, disp_d, shifted;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;

  if (DIGITS == 1) begin : g_single
    assign shifted = digit_i;
  end else begin : g_multi
    assign shifted = {disp_q[W-5:0], digit_i};
  end

  always_comb begin
    disp_d  = disp_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    if (clr_i) begin
      disp_d  = '0;
      count_d = '0;
    end else if (push_i) begin
      if (count_q != Full) begin
        disp_d  = shifted;
        count_d = count_q + CntW'(1);
      end else begin
        ovf_d = 1'b1;
        if (OVF_SHIFT == OvfShift) begin
          disp_d = shifted;
        end
      end
    end else if (pop_i && (count_q != '0)) begin
      disp_d  = disp_q >> 4;
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      disp_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      disp_q  <= disp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign disp_o  = disp_q;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/keypad_entry.sv
// Digit-entry controller between the keypad front end and a consumer.
// Detects one event per key press, routes digits/commands into the digit
// buffer, commits entries over a valid/ready handshake and optionally
// auto-clears a partial entry after TIMEOUT idle cycles.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : keypad_entry_if slave (key inputs, display, handshake, pulses)
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned OVF_SHIFT   = OvfSat,
  parameter logic [3:0]  ENTER_CODE  = KeyEnter,
  parameter logic [3:0]  BACK_CODE   = KeyBack,
  parameter logic [3:0]  CLR_CODE    = KeyClr,
  parameter int unsigned ALLOW_EMPTY = 0,
  parameter int unsigned TIMEOUT     = 0
) (
  input  logic           clk,
  input  logic           reset,
  keypad_entry_if.slave  bus
);

  localparam int unsigned W     = DIGITS * 4;
  localparam int unsigned CntW  = $clog2(DIGITS + 1);
  localparam int unsigned IdleW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IdleW-1:0] IdleLast = (TIMEOUT > 0) ? IdleW'(TIMEOUT - 1) : '0;

  state_e           state_q;
  logic             kv_q;
  logic [W-1:0]     out_data_q;
  logic             out_valid_q;
  logic             timeout_q;
  logic [IdleW-1:0] idle_q;

  logic             key_evt;
  key_kind_e        kind;
  logic             in_entry;
  logic             push, pop, clr, commit, tmo_fire;
  logic [W-1:0]     buf_disp;
  logic [CntW-1:0]  buf_count;
  logic             buf_ovf;

  // kv_q resets high so a key already held at reset release is not an event.
  assign key_evt  = bus.key_valid & ~kv_q;
  assign kind     = classify_key(bus.key_code, ENTER_CODE, BACK_CODE, CLR_CODE);
  assign in_entry = (state_q == StEntry);

  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    commit   = 1'b0;
    clr      = 1'b0;
    tmo_fire = 1'b0;
    if (in_entry) begin
      if (key_evt) begin
        unique case (kind)
          KindDigit: push   = 1'b1;
          KindBack:  pop    = 1'b1;
          KindClr:   clr    = 1'b1;
          KindEnter: commit = (buf_count != '0) || (ALLOW_EMPTY != 0);
          default:   ;
        endcase
      end else if ((TIMEOUT > 0) && (buf_count != '0) && (idle_q == IdleLast)) begin
        // Any key event this cycle, even an ignored enter, suppresses the timeout.
        tmo_fire = 1'b1;
      end
    end
  end

  keypad_entry_digit_buffer #(
    .DIGITS    (DIGITS),
    .OVF_SHIFT (OVF_SHIFT)
  ) u_digit_buffer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .pop_i   (pop),
    .clr_i   (clr | commit | tmo_fire),
    .digit_i (bus.key_code),
    .disp_o  (buf_disp),
    .count_o (buf_count),
    .ovf_o   (buf_ovf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StEntry;
      kv_q        <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      idle_q      <= '0;
    end else begin
      kv_q      <= bus.key_valid;
      timeout_q <= tmo_fire;

      case (state_q)
        StEntry: begin
          if (commit) begin
            out_data_q  <= buf_disp;
            out_valid_q <= 1'b1;
            state_q     <= StHold;
          end
        end
        StHold: begin
          // Key events are swallowed here, including one on the handshake edge.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StEntry;
          end
        end
        default: state_q <= StEntry;
      endcase

      if ((TIMEOUT == 0) || !in_entry || key_evt || (buf_count == '0) || tmo_fire) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + IdleW'(1);
      end
    end
  end

  assign bus.disp      = buf_disp;
  assign bus.count     = buf_count;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = buf_ovf;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = (state_q == StHold);

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry. Three instances share clock and reset:
//   u0: saturate, no empty enter, no timeout
//   u1: shift on overflow, empty enter allowed, no timeout
//   u2: saturate, TIMEOUT=10
// Committed entries are queued when enter is pressed and popped on handshake.
module tb_keypad_entry;

  logic clk;
  logic reset;

  logic       kv  [3];
  logic [3:0] kc  [3];
  logic       rdy [3];

  logic [15:0] disp_w [3];
  logic [2:0]  cnt_w  [3];
  logic [15:0] od_w   [3];
  logic        ov_w   [3];
  logic        ovf_w  [3];
  logic        tmo_w  [3];
  logic        busy_w [3];

  keypad_entry_if #(.DIGITS(4)) if0 ();
  keypad_entry_if #(.DIGITS(4)) if1 ();
  keypad_entry_if #(.DIGITS(4)) if2 ();

  keypad_entry #(.DIGITS(4), .OVF_SHIFT(0), .ALLOW_EMPTY(0), .TIMEOUT(0))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  keypad_entry #(.DIGITS(4), .OVF_SHIFT(1), .ALLOW_EMPTY(1), .TIMEOUT(0))
    u1 (.clk(clk), .reset(reset), .bus(if1));
  keypad_entry #(.DIGITS(4), .OVF_SHIFT(0), .ALLOW_EMPTY(0), .TIMEOUT(10))
    u2 (.clk(clk), .reset(reset), .bus(if2));

  assign if0.key_valid = kv[0];  assign if0.key_code = kc[0];  assign if0.out_ready = rdy[0];
  assign if1.key_valid = kv[1];  assign if1.key_code = kc[1];  assign if1.out_ready = rdy[1];
  assign if2.key_valid = kv[2];  assign if2.key_code = kc[2];  assign if2.out_ready = rdy[2];

  assign disp_w[0] = if0.disp;      assign disp_w[1] = if1.disp;      assign disp_w[2] = if2.disp;
  assign cnt_w[0]  = if0.count;     assign cnt_w[1]  = if1.count;     assign cnt_w[2]  = if2.count;
  assign od_w[0]   = if0.out_data;  assign od_w[1]   = if1.out_data;  assign od_w[2]   = if2.out_data;
  assign ov_w[0]   = if0.out_valid; assign ov_w[1]   = if1.out_valid; assign ov_w[2]   = if2.out_valid;
  assign ovf_w[0]  = if0.overflow;  assign ovf_w[1]  = if1.overflow;  assign ovf_w[2]  = if2.overflow;
  assign tmo_w[0]  = if0.timeout;   assign tmo_w[1]  = if1.timeout;   assign tmo_w[2]  = if2.timeout;
  assign busy_w[0] = if0.busy;      assign busy_w[1] = if1.busy;      assign busy_w[2] = if2.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] sb_q [$];
  logic last_ovf;
  logic last_tmo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One press: event on the first edge with key_valid high, released after it.
  task automatic press(input int idx, input logic [3:0] code);
    @(posedge clk); #2;
    kv[idx] = 1'b1;
    kc[idx] = code;
    @(posedge clk); #2;
    last_ovf = ovf_w[idx];
    last_tmo = tmo_w[idx];
    kv[idx] = 1'b0;
  endtask

  task automatic check_buf(input string tag, input int idx, input logic [15:0] d,
                           input logic [2:0] c);
    check({tag, "_disp"}, 32'(disp_w[idx]), 32'(d));
    check({tag, "_count"}, 32'(cnt_w[idx]), 32'(c));
  endtask

  // Keep out_ready low for ready_delay cycles, then complete the handshake.
  task automatic wait_commit(input int idx, input int ready_delay);
    bit seen = 1'b0;
    for (int i = 0; i < ready_delay; i++) begin
      @(posedge clk); #2;
      check("hold_valid", 32'(ov_w[idx]), 32'd1);
      check("hold_busy", 32'(busy_w[idx]), 32'd1);
      if (sb_q.size() > 0) check("hold_data", 32'(od_w[idx]), 32'(sb_q[0]));
    end
    rdy[idx] = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ov_w[idx] && rdy[idx]) begin
        seen = 1'b1;
        check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) check("commit_data", 32'(od_w[idx]), 32'(sb_q.pop_front()));
      end
    end
    check("commit_seen", 32'(seen), 32'd1);
    @(posedge clk); #2;
    rdy[idx] = 1'b0;
    check("after_ready_valid", 32'(ov_w[idx]), 32'd0);
    check("after_ready_busy", 32'(busy_w[idx]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      kv[i] = 1'b0; kc[i] = 4'h0; rdy[i] = 1'b0;
    end
    last_ovf = 1'b0;
    last_tmo = 1'b0;

    // Reset with a key already held on u0
    reset = 1'b0;
    kv[0] = 1'b1; kc[0] = 4'h5;
    repeat (3) @(posedge clk);
    #1;
    check_buf("rst", 0, 16'h0000, 3'd0);
    check("rst_out_valid", 32'(ov_w[0]), 32'd0);
    check("rst_out_data", 32'(od_w[0]), 32'd0);
    check("rst_busy", 32'(busy_w[0]), 32'd0);
    check("rst_overflow", 32'(ovf_w[0]), 32'd0);
    check("rst_timeout", 32'(tmo_w[0]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check_buf("held_thru_reset", 0, 16'h0000, 3'd0);
    kv[0] = 1'b0;
    @(posedge clk); #2;

    // Basic entry and commit with delayed ready; key during HOLD ignored
    press(0, 4'h1);
    press(0, 4'h2);
    press(0, 4'h3);
    check_buf("entry123", 0, 16'h0123, 3'd3);
    check("entry_no_valid", 32'(ov_w[0]), 32'd0);
    sb_q.push_back(16'h0123);
    press(0, 4'hA);
    check("enter_valid", 32'(ov_w[0]), 32'd1);
    check("enter_busy", 32'(busy_w[0]), 32'd1);
    check_buf("enter_cleared", 0, 16'h0000, 3'd0);
    press(0, 4'h6);
    check_buf("hold_key_ignored", 0, 16'h0000, 3'd0);
    wait_commit(0, 3);
    check_buf("post_commit", 0, 16'h0000, 3'd0);

    // Overflow: saturate on u0, shift on u1
    for (int d = 1; d <= 4; d++) begin
      press(0, 4'(d));
      press(1, 4'(d));
    end
    check("ovf_not_at_4", 32'(last_ovf), 32'd0);
    check_buf("full_sat", 0, 16'h1234, 3'd4);
    press(0, 4'h5);
    check("ovf_sat_pulse", 32'(last_ovf), 32'd1);
    check_buf("ovf_sat", 0, 16'h1234, 3'd4);
    @(posedge clk); #2;
    check("ovf_sat_single", 32'(ovf_w[0]), 32'd0);
    press(1, 4'h5);
    check("ovf_shift_pulse", 32'(last_ovf), 32'd1);
    check_buf("ovf_shift", 1, 16'h2345, 3'd4);
    @(posedge clk); #2;
    check("ovf_shift_single", 32'(ovf_w[1]), 32'd0);
    press(0, 4'hC);
    press(1, 4'hC);
    check_buf("clr_u0", 0, 16'h0000, 3'd0);
    check_buf("clr_u1", 1, 16'h0000, 3'd0);

    // Backspace, underflow protection, clear
    press(0, 4'h7);
    press(0, 4'h8);
    check_buf("bs_pre", 0, 16'h0078, 3'd2);
    press(0, 4'hB);
    check_buf("bs1", 0, 16'h0007, 3'd1);
    press(0, 4'hB);
    check_buf("bs2", 0, 16'h0000, 3'd0);
    press(0, 4'hB);
    check_buf("bs3_underflow", 0, 16'h0000, 3'd0);
    press(0, 4'h9);
    check_buf("bs_then9", 0, 16'h0009, 3'd1);
    press(0, 4'hC);
    check_buf("bs_clear", 0, 16'h0000, 3'd0);

    // Long hold: one event only
    @(posedge clk); #2;
    kv[0] = 1'b1; kc[0] = 4'h5;
    repeat (20) @(posedge clk);
    #2;
    kv[0] = 1'b0;
    check_buf("long_hold", 0, 16'h0005, 3'd1);
    press(0, 4'hC);

    // Empty enter: ignored on u0, commits 0 on u1
    press(0, 4'hA);
    check("empty_enter_valid", 32'(ov_w[0]), 32'd0);
    check("empty_enter_busy", 32'(busy_w[0]), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    check("empty_enter_later", 32'(ov_w[0]), 32'd0);
    sb_q.push_back(16'h0000);
    press(1, 4'hA);
    check("allow_empty_valid", 32'(ov_w[1]), 32'd1);
    wait_commit(1, 2);

    // Timeout fires on the tenth idle cycle
    press(2, 4'h3);
    check_buf("tmo_pre", 2, 16'h0003, 3'd1);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #2;
      check("tmo_quiet", 32'(tmo_w[2]), 32'd0);
    end
    @(posedge clk); #2;
    check("tmo_pulse", 32'(tmo_w[2]), 32'd1);
    check_buf("tmo_cleared", 2, 16'h0000, 3'd0);
    @(posedge clk); #2;
    check("tmo_single", 32'(tmo_w[2]), 32'd0);

    // A key on the would-be timeout edge wins
    press(2, 4'h3);
    repeat (8) begin
      @(posedge clk); #2;
      check("tmo_quiet2", 32'(tmo_w[2]), 32'd0);
    end
    press(2, 4'h4);
    check("tmo_suppressed", 32'(last_tmo), 32'd0);
    check_buf("tmo_key_wins", 2, 16'h0034, 3'd2);
    repeat (3) @(posedge clk);
    #2;
    check("tmo_after_key", 32'(tmo_w[2]), 32'd0);
    press(2, 4'hC);

    // Reset mid-operation drops out_valid immediately
    press(0, 4'h1);
    press(0, 4'hA);
    check("pre_reset_valid", 32'(ov_w[0]), 32'd1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("async_reset_valid", 32'(ov_w[0]), 32'd0);
    check("async_reset_busy", 32'(busy_w[0]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #2;
    check_buf("post_reset", 0, 16'h0000, 3'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Digit-entry controller that sits between keypad_base (key value + valid) and the consumer logic.
- Accumulates up to DIGITS hex nibbles. Supports backspace, clear and enter command keys, overflow policy and inactivity timeout.
- Delivers a committed entry over a valid/ready handshake.
- Successor to the plain shift-register capture path.

Parameters:
- DIGITS, 4: maximum nibbles held; entry width is DIGITS*4.
- OVF_SHIFT, 0: 0 = saturate, so extra digits are dropped; 1 = shift, so the oldest digit is discarded.
- ENTER_CODE, 4'hA: key value that commits the entry.
- BACK_CODE, 4'hB: key value that deletes the last digit.
- CLR_CODE, 4'hC: key value that clears the buffer.
- ALLOW_EMPTY, 0: 1 = enter with zero digits commits the value 0.
- TIMEOUT, 0: idle cycles before a partial entry auto-clears; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- key_valid  in  1  keypad valid level (keypad_base valid), synchronous to clk
- key_code  in  4  keypad value, stable while key_valid is high
- disp  out  DIGITS*4  live buffer contents; least-significant nibble is the newest digit
- count  out  $clog2(DIGITS+1)  number of digits currently held
- out_data  out  DIGITS*4  committed entry
- out_valid  out  1  committed entry available
- out_ready  in  1  consumer accepts out_data
- overflow  out  1  one-cycle pulse when a digit arrives with count==DIGITS
- timeout  out  1  one-cycle pulse when an auto-clear occurs
- busy  out  1  high in HOLD state

Behaviour:
- Reset (reset low, asynchronous):
  - disp=0, count=0, out_data=0, out_valid=0, overflow=0, timeout=0, busy=0, state=ENTRY, idle counter=0.
  - Edge register kv_q is reset to 1, so a key held across reset release is not accepted.
- Key event:
  - event = key_valid & ~kv_q, evaluated at a clk edge; kv_q <= key_valid every cycle in all states.
  - The effect of an event is visible after that same edge (latency 1 cycle from key_valid rise).
  - Exactly one event per press, regardless of hold length.
- Classification: key_code equal to ENTER_CODE/BACK_CODE/CLR_CODE is a command; every other code, including D-F, is a digit. Command matching takes priority.
- ENTRY state:
  - Digit, count<DIGITS: disp <= {disp[DIGITS*4-5:0], key_code}; count++.
  - Digit, count==DIGITS, OVF_SHIFT=0: disp and count unchanged; overflow pulses.
  - Digit, count==DIGITS, OVF_SHIFT=1: shift as above, the MS nibble is lost, count stays DIGITS; overflow pulses.
  - Backspace: disp <= disp>>4 (zero fill); count--. If count==0, no-op.
  - Clear: disp=0, count=0.
  - Enter, count>0 or ALLOW_EMPTY=1:
    - out_data <= disp; out_valid <= 1.
    - disp=0, count=0.
    - Next state HOLD.
  - Enter with count==0 and ALLOW_EMPTY=0: ignored.
- HOLD state:
  - busy=1; all key events are consumed and discarded (kv_q still tracks).
  - out_valid holds until a clk edge with out_ready=1; at that edge out_valid<=0 and state becomes ENTRY.
  - out_data is held stable while out_valid=1.
  - out_ready is ignored in ENTRY, including on the same cycle as enter.
  - A key event on the same edge as the handshake is discarded.
- Timeout (TIMEOUT>0):
  - The idle counter increments each cycle in ENTRY while count>0.
  - It zeroes on any key event, when count==0, and in HOLD.
  - When it reaches TIMEOUT-1 with no event that cycle: disp=0, count=0, timeout pulses, counter zeroes.
  - A key event on that same cycle wins: no timeout, and the event is processed.
- Reset mid-operation: out_valid drops immediately (asynchronous); any pending entry is lost.
- Widths:
  - count width is $clog2(DIGITS+1); the idle counter is $clog2(TIMEOUT+1) wide, minimum 1.
  - DIGITS>=1; when DIGITS==1 the shift keeps only key_code.

Decomposition:
- keypad_pkg holds:
  - default key-code constants (ENTER/BACK/CLR);
  - state encoding (ENTRY, HOLD);
  - overflow-mode constants (OVF_SAT=0, OVF_SHIFT=1).
- One natural sub-module: digit_buffer (parametrised nibble shift register with push/pop/clear, disp and count outputs, overflow flag). keypad_entry keeps the edge detect, FSM, timeout counter and handshake.

Test Plan:
- DIGITS=4: press 1,2,3,A; out_ready=0 for 5 cycles, then 1 -> out_data=16'h0123, out_valid high until the ready edge; disp=0, count=0 after enter; busy=1 during HOLD.
- OVF_SHIFT=0: press 1,2,3,4,5 -> disp=16'h1234, count=4, overflow single pulse on 5. Rerun with OVF_SHIFT=1 -> disp=16'h2345, count=4.
- Press 7,8,B,B,B, then 9 -> disp=16'h0007, then 0, then 0 (no underflow); after 9, disp=16'h0009 and count=1. Press C -> disp=0.
- Hold key_valid high 20 cycles with code 5 -> count increments once only. Key held across reset release -> no digit captured.
- ALLOW_EMPTY=0: press A with empty buffer -> no out_valid. During HOLD, press 6 -> ignored, disp stays 0.
- TIMEOUT=10: press 3, idle 10 cycles -> timeout pulse at cycle 10, disp=0, count=0. Press 3, then a key on cycle 9 -> no timeout.
